sync_pattern_src: RTL and testbench



---
 rtl/sync_pattern_pkg.sv | 28 ++
 rtl/sync_pattern_src_if.sv | 26 ++
 rtl/sync_pattern_chan.sv | 63 ++++++
 rtl/sync_pattern_src.sv | 114 +++++++++++
 tb/tb_sync_pattern_src.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_pattern_pkg.sv
// Shared types and constants for the multi-channel clocked pattern source.
// Widths here are the maxima over the legal parameter range; modules zero-extend into them.
package sync_pattern_pkg;

    localparam int CNT_W       = 16;
    localparam int CHAN_W_MAX  = 5;
    localparam int PAT_LEN_MAX = 64;
    localparam int PHASE_W_MAX = 6;

    typedef enum logic [1:0] {
        ALWAYS0 = 2'd0,
        ALWAYS1 = 2'd1,
        PATTERN = 2'd2,
        ONESHOT = 2'd3
    } mode_e;

    typedef struct packed {
        logic [CHAN_W_MAX-1:0]  chan;
        mode_e                  mode;
        logic [PAT_LEN_MAX-1:0] pattern;
    } cfg_req_t;

    // Channel index width, never narrower than one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_pattern_src_if.sv
// Configuration request bus of sync_pattern_src: valid/ready request plus error pulse.
// The master drives requests; the slave (the pattern source) returns ready and error.
interface sync_pattern_src_if #(
    parameter int CHANNELS    = 4,
    parameter int PATTERN_LEN = 8
) ();
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [CW-1:0]          cfg_chan;
    logic [1:0]             cfg_mode;
    logic [PATTERN_LEN-1:0] cfg_pattern;
    logic                   cfg_err;

    modport master (
        output cfg_valid, cfg_chan, cfg_mode, cfg_pattern,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_mode, cfg_pattern,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/sync_pattern_chan.sv
// One output channel: active mode/pattern, one-shot completion flag and the q flop.
// New configuration is loaded only on the phase wrap edge, so q never changes rule mid-period.
module sync_pattern_chan
    import sync_pattern_pkg::*;
#(
    parameter  int PATTERN_LEN = 8,
    localparam int PW          = $clog2(PATTERN_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PW-1:0]          i_phase,
    input  logic                   i_commit,
    input  mode_e                  i_mode,
    input  logic [PAT_LEN_MAX-1:0] i_pattern,
    output logic                   o_q
);

    mode_e                  r_mode;
    logic [PAT_LEN_MAX-1:0] r_pat;
    logic                   r_done;
    logic                   r_q;

    logic w_wrap;
    logic w_bit;
    logic w_q_next;

    assign w_wrap = (i_phase == PW'(PATTERN_LEN - 1));
    assign w_bit  = r_pat[PHASE_W_MAX'(i_phase)];
    assign o_q    = r_q;

    always_comb begin
        w_q_next = 1'b0;
        case (r_mode)
            ALWAYS0: w_q_next = 1'b0;
            ALWAYS1: w_q_next = 1'b1;
            PATTERN: w_q_next = w_bit;
            ONESHOT: w_q_next = w_bit & ~r_done;
            default: w_q_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= ALWAYS0;
            r_pat  <= '0;
            r_done <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_q <= w_q_next;
            // A commit on the wrap edge restarts a one-shot instead of completing it.
            if (w_wrap) begin
                if (i_commit) begin
                    r_mode <= i_mode;
                    r_pat  <= i_pattern;
                    r_done <= 1'b0;
                end else if (r_mode == ONESHOT) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sync_pattern_src.sv
// Multi-channel clocked constant/pattern source sharing one phase counter and one pending config slot.
// Optional per-channel high-cycle counters are built when SYNC_PATTERN_SRC_PULSE_CNT_EN is defined.
module sync_pattern_src
    import sync_pattern_pkg::*;
#(
    parameter  int CHANNELS    = 4,
    parameter  int PATTERN_LEN = 8,
    localparam int CW          = chan_w(CHANNELS),
    localparam int PW          = $clog2(PATTERN_LEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    sync_pattern_src_if.slave   cfg,
    output logic [PW-1:0]       phase,
    output logic [CHANNELS-1:0] q
`ifdef SYNC_PATTERN_SRC_PULSE_CNT_EN
    ,
    input  logic [CW-1:0]       cnt_sel,
    input  logic                cnt_clr,
    output logic [CNT_W-1:0]    cnt_val
`endif
);

    logic [PW-1:0] r_phase;
    logic          r_pend_full;
    cfg_req_t      r_pend;
    logic          r_err;

    logic w_wrap;
    logic w_xfer;
    logic w_legal;
    logic w_commit;

    assign w_wrap   = (r_phase == PW'(PATTERN_LEN - 1));
    assign w_xfer   = cfg.cfg_valid && cfg.cfg_ready;
    assign w_legal  = (int'(cfg.cfg_chan) < CHANNELS);
    assign w_commit = r_pend_full && w_wrap;

    // An illegal request still occupies the handshake for the one cycle its error is flagged.
    assign cfg.cfg_ready = !r_pend_full && !r_err;
    assign cfg.cfg_err   = r_err;
    assign phase         = r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase     <= '0;
            r_pend_full <= 1'b0;
            r_pend      <= '0;
            r_err       <= 1'b0;
        end else begin
            r_phase <= w_wrap ? '0 : r_phase + 1'b1;
            r_err   <= 1'b0;
            if (w_commit) begin
                r_pend_full <= 1'b0;
            end
            if (w_xfer) begin
                if (w_legal) begin
                    r_pend_full    <= 1'b1;
                    r_pend.chan    <= CHAN_W_MAX'(cfg.cfg_chan);
                    r_pend.mode    <= mode_e'(cfg.cfg_mode);
                    r_pend.pattern <= PAT_LEN_MAX'(cfg.cfg_pattern);
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef SYNC_PATTERN_SRC_PULSE_CNT_EN
    logic [CNT_W-1:0] w_cnt [CHANNELS];
`endif

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic w_chan_commit;

            assign w_chan_commit = w_commit && (r_pend.chan == CHAN_W_MAX'(gi));

            sync_pattern_chan #(
                .PATTERN_LEN (PATTERN_LEN)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .i_phase   (r_phase),
                .i_commit  (w_chan_commit),
                .i_mode    (r_pend.mode),
                .i_pattern (r_pend.pattern),
                .o_q       (q[gi])
            );

`ifdef SYNC_PATTERN_SRC_PULSE_CNT_EN
            logic [CNT_W-1:0] r_cnt;

            // Clear wins over increment; the count sticks at all-ones.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (cnt_clr) begin
                    r_cnt <= '0;
                end else if (q[gi] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign w_cnt[gi] = r_cnt;
`endif
        end
    endgenerate

`ifdef SYNC_PATTERN_SRC_PULSE_CNT_EN
    assign cnt_val = (int'(cnt_sel) < CHANNELS) ? w_cnt[cnt_sel] : '0;
`endif

endmodule

// File: tb/tb_sync_pattern_src.sv
// Bench for sync_pattern_src: a time-based model checks the 4-channel instance every cycle,
// directed literal checks pin the model; a 3-channel instance exercises the illegal-channel path.
module tb_sync_pattern_src;
    import sync_pattern_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_pattern_src_if #(.CHANNELS(4), .PATTERN_LEN(8)) cfg_a ();
    sync_pattern_src_if #(.CHANNELS(3), .PATTERN_LEN(4)) cfg_b ();

    logic [2:0] phase_a;
    logic [3:0] q_a;
    logic [1:0] phase_b;
    logic [2:0] q_b;

`ifdef SYNC_PATTERN_SRC_PULSE_CNT_EN
    logic [1:0]       cnt_sel_a = '0;
    logic [1:0]       cnt_sel_b = '0;
    logic             cnt_clr   = 1'b0;
    logic [CNT_W-1:0] cnt_val_a;
    logic [CNT_W-1:0] cnt_val_b;
`endif

    sync_pattern_src #(.CHANNELS(4), .PATTERN_LEN(8)) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg_a),
        .phase   (phase_a),
        .q       (q_a)
`ifdef SYNC_PATTERN_SRC_PULSE_CNT_EN
        ,
        .cnt_sel (cnt_sel_a),
        .cnt_clr (cnt_clr),
        .cnt_val (cnt_val_a)
`endif
    );

    sync_pattern_src #(.CHANNELS(3), .PATTERN_LEN(4)) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg     (cfg_b),
        .phase   (phase_b),
        .q       (q_b)
`ifdef SYNC_PATTERN_SRC_PULSE_CNT_EN
        ,
        .cnt_sel (cnt_sel_b),
        .cnt_clr (cnt_clr),
        .cnt_val (cnt_val_b)
`endif
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Model: edge n after reset; a config committed at edge e drives q from edge e+1,
    // using bit (n-1-e) mod 8 of its pattern.
    int         m_n = 0;
    int         m_mode [4] = '{0, 0, 0, 0};
    logic [7:0] m_pat  [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
    int         m_e    [4] = '{0, 0, 0, 0};
    bit         m_pv = 1'b0;
    int         m_pc = 0;
    int         m_pm = 0;
    logic [7:0] m_pp = '0;
    int         m_pe = 0;
    logic [3:0] m_q = '0;
    int         m_phase = 0;
    bit         m_ready = 1'b1;

    function automatic logic ch_out(input int c, input int n);
        int offs;
        offs = n - 1 - m_e[c];
        case (m_mode[c])
            1:       return 1'b1;
            2:       return m_pat[c][offs % 8];
            3:       return (offs < 8) ? m_pat[c][offs] : 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0;
            for (int c = 0; c < 4; c++) begin
                m_mode[c] = 0;
                m_pat[c]  = '0;
                m_e[c]    = 0;
            end
            m_pv = 1'b0;
            m_q = '0;
            m_phase = 0;
            m_ready = 1'b1;
        end else begin
            int  n;
            bit  xfer;
            n = m_n + 1;
            xfer = cfg_a.cfg_valid && m_ready;
            for (int c = 0; c < 4; c++) m_q[c] = ch_out(c, n);
            if (m_pv && (m_pe == n)) begin
                m_mode[m_pc] = m_pm;
                m_pat[m_pc]  = m_pp;
                m_e[m_pc]    = n;
                m_pv = 1'b0;
            end
            if (xfer) begin
                m_pv = 1'b1;
                m_pc = int'(cfg_a.cfg_chan);
                m_pm = int'(cfg_a.cfg_mode);
                m_pp = cfg_a.cfg_pattern;
                m_pe = (n / 8 + 1) * 8;
            end
            m_ready = !m_pv;
            m_phase = n % 8;
            m_n = n;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_on) begin
            chk("cmp_q", int'(q_a), int'(m_q));
            chk("cmp_phase", int'(phase_a), m_phase);
            chk("cmp_ready", int'(cfg_a.cfg_ready), int'(m_ready));
            chk("cmp_err", int'(cfg_a.cfg_err), 0);
        end
    end

    task automatic wait_phase_a(input int p);
        for (int i = 0; i < 20; i++) begin
            if (int'(phase_a) == p) return;
            @(negedge clk);
        end
        timeout("wait_phase");
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_a(input int ch, input int mode, input logic [7:0] pat);
        bit ok;
        ok = 1'b0;
        cfg_a.cfg_valid   = 1'b1;
        cfg_a.cfg_chan    = 2'(ch);
        cfg_a.cfg_mode    = 2'(mode);
        cfg_a.cfg_pattern = pat;
        for (int i = 0; i < 40; i++) begin
            if (cfg_a.cfg_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cfg_a.cfg_valid = 1'b0;
        if (!ok) timeout("send_a");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  v8;
        logic [23:0] v24;
        int          ones;
        int          cnt2;
        int          errs;
        logic [3:0]  q_or;

        cfg_a.cfg_valid = 1'b0; cfg_a.cfg_chan = '0; cfg_a.cfg_mode = '0; cfg_a.cfg_pattern = '0;
        cfg_b.cfg_valid = 1'b0; cfg_b.cfg_chan = '0; cfg_b.cfg_mode = '0; cfg_b.cfg_pattern = '0;

        repeat (2) @(negedge clk);
        chk("reset_q", int'(q_a), 0);
        chk("reset_ready", int'(cfg_a.cfg_ready), 1);
        #2 rst_n = 1'b1;
        chk_on = 1'b1;

        // 1: idle after reset
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("t1_phase", int'(phase_a), i % 8);
            chk("t1_q", int'(q_a), 0);
            chk("t1_ready", int'(cfg_a.cfg_ready), 1);
        end
        $display("t1 idle: 20 cycles checked");

        // 2: ch1 PATTERN 1010_0110 transferred at phase 3
        wait_phase_a(3);
        send_a(1, 2, 8'hA6);
        chk("t2_ready_low", int'(cfg_a.cfg_ready), 0);
        wait_phase_a(7);
        chk("t2_ready_low_p7", int'(cfg_a.cfg_ready), 0);
        @(negedge clk);
        chk("t2_ready_back", int'(cfg_a.cfg_ready), 1);
        v8 = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("t2_first_phase", int'(phase_a), 1);
            v8[i] = q_a[1];
        end
        chk("t2_pattern", int'(v8), 32'hA6);
        $display("t2 pattern ch1: bits=%b", v8);

        // 3: ch2 ALWAYS1 transferred exactly at phase 7
        wait_phase_a(7);
        send_a(2, 1, 8'h00);
        v24 = '0;
        v24[0] = q_a[2];
        for (int k = 1; k < 24; k++) begin
            @(negedge clk);
            v24[k] = q_a[2];
        end
        chk("t3_always1", int'(v24), 32'hFFFE00);
        $display("t3 always1 ch2: trace=%h", v24);

        // 4: ch0 ONESHOT 0xFF, then recommit
        for (int r = 0; r < 2; r++) begin
            send_a(0, 3, 8'hFF);
            ones = 0;
            cnt2 = 0;
            for (int k = 0; k < 24; k++) begin
                @(negedge clk);
                ones += int'(q_a[0]);
                cnt2 += int'(q_a[2]);
            end
            chk("t4_oneshot_ones", ones, 8);
            chk("t4_ch2_held", cnt2, 24);
            $display("t4 oneshot ch0 round %0d: ones=%0d", r, ones);
        end

        // 5: illegal channel on the 3-channel instance
        cfg_b.cfg_valid = 1'b1;
        cfg_b.cfg_chan  = 2'd3;
        cfg_b.cfg_mode  = 2'd1;
        cfg_b.cfg_pattern = 4'hF;
        chk("t5_ready_pre", int'(cfg_b.cfg_ready), 1);
        @(negedge clk);
        cfg_b.cfg_valid = 1'b0;
        chk("t5_err_pulse", int'(cfg_b.cfg_err), 1);
        chk("t5_ready_low", int'(cfg_b.cfg_ready), 0);
        @(negedge clk);
        chk("t5_err_gone", int'(cfg_b.cfg_err), 0);
        chk("t5_ready_back", int'(cfg_b.cfg_ready), 1);
        errs = 0;
        q_or = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            errs += int'(cfg_b.cfg_err);
            q_or[2:0] = q_or[2:0] | q_b;
        end
        chk("t5_no_more_err", errs, 0);
        chk("t5_q_quiet", int'(q_or), 0);
        $display("t5 illegal chan: errs_after=%0d q_or=%b", errs, q_or);

        // 6: reset while ch3 request is pending
        wait_phase_a(2);
        send_a(3, 1, 8'h00);
        chk("t6_pending", int'(cfg_a.cfg_ready), 0);
        chk("t6_ch2_before", int'(q_a[2]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_q", int'(q_a), 0);
        chk("t6_rst_ready", int'(cfg_a.cfg_ready), 1);
        chk("t6_rst_phase", int'(phase_a), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        q_or = '0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            q_or = q_or | q_a;
        end
        chk("t6_after_rst", int'(q_or), 0);
        $display("t6 reset mid-pending: q_or=%b", q_or);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
